// File: rtl/reg_status_file.sv
// rtl/reg_status_file.sv - architectural register file plus register alias table feeding the ROB
// Optional feature macro: REG_STATUS_COMMIT_BYPASS_EN (same-cycle commit bypass on source lookup)
module reg_status_file #(
  parameter int ROB_DEPTH = 8,
  parameter int TW        = $clog2(ROB_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          dispatch_valid,
  input  logic [4:0]    dispatch_rd_s,
  input  logic [TW-1:0] dispatch_rob,
  input  logic [4:0]    rs1_s,
  input  logic [4:0]    rs2_s,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic [TW-1:0] rs1_rob,
  output logic [TW-1:0] rs2_rob,
  output logic [31:0]   rs1_v,
  output logic [31:0]   rs2_v,
  input  logic          commit_valid,
  input  logic [4:0]    commit_rd_s,
  input  logic [TW-1:0] commit_rob,
  input  logic [31:0]   commit_rd_v,
  output logic [63:0]   order_next
);

  logic [31:0]   r_regs [1:31];
  logic          r_busy [1:31];
  logic [TW-1:0] r_tag  [1:31];
  logic [63:0]   r_dispatch_count;
  logic [63:0]   r_commit_count;

  logic          w_dispatch_en;
  logic          w_commit_en;
  logic [63:0]   w_commit_inc;

  // Writes to x0 are dropped; a dispatch in a flush cycle is discarded entirely.
  assign w_dispatch_en = dispatch_valid && !flush && (dispatch_rd_s != 5'd0);
  assign w_commit_en   = commit_valid && (commit_rd_s != 5'd0);
  assign w_commit_inc  = {63'd0, commit_valid};
  assign order_next    = r_dispatch_count;

  // Source lookup: {busy, rob, value} from pre-edge state, x0 always reads as ready zero.
  function automatic logic [TW+32:0] f_lookup(input logic [4:0] i_s);
    logic          busy;
    logic [TW-1:0] rob;
    logic [31:0]   v;
    busy = 1'b0;
    rob  = '0;
    v    = '0;
    if (i_s != 5'd0) begin
      busy = r_busy[i_s];
      rob  = r_tag[i_s];
      v    = r_regs[i_s];
`ifdef REG_STATUS_COMMIT_BYPASS_EN
      // The producer retires this cycle, so its value is forwarded instead of waiting.
      if (commit_valid && (commit_rd_s == i_s) && (r_tag[i_s] == commit_rob)) begin
        busy = 1'b0;
        v    = commit_rd_v;
      end
`endif
    end
    return {busy, rob, v};
  endfunction

  // Combinational operand resolution for both sources.
  always_comb begin
    {rs1_busy, rs1_rob, rs1_v} = f_lookup(rs1_s);
    {rs2_busy, rs2_rob, rs2_v} = f_lookup(rs2_s);
  end

  // Register values, alias mappings and order counters; dispatch mapping overrides a same-rd commit clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
        r_busy[i] <= 1'b0;
        r_tag[i]  <= '0;
      end
      r_dispatch_count <= '0;
      r_commit_count   <= '0;
    end else begin
      if (w_commit_en) begin
        r_regs[commit_rd_s] <= commit_rd_v;
        if (r_tag[commit_rd_s] == commit_rob) begin
          r_busy[commit_rd_s] <= 1'b0;
        end
      end
      if (w_dispatch_en) begin
        r_busy[dispatch_rd_s] <= 1'b1;
        r_tag[dispatch_rd_s]  <= dispatch_rob;
      end
      if (flush) begin
        for (int i = 1; i < 32; i++) begin
          r_busy[i] <= 1'b0;
        end
      end
      r_commit_count <= r_commit_count + w_commit_inc;
      if (flush) begin
        r_dispatch_count <= r_commit_count + w_commit_inc;
      end else if (dispatch_valid) begin
        r_dispatch_count <= r_dispatch_count + 64'd1;
      end
    end
  end

endmodule

// File: doc/reg_status_file.md
# reg_status_file

Architectural register file plus register alias table, sitting directly upstream of the reorder buffer in the out-of-order core. It resolves source operands at dispatch, returning either the committed value or the ROB tag of the in-flight producer. It records each new destination mapping, takes architectural writes from ROB commit, and generates the `rvfi_order` stamp the ROB stores with each pushed entry.

## Interface
- `ROB_DEPTH`, 8: ROB entries; tag width `TW = $clog2(ROB_DEPTH)`.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-low.
- `flush  in  1`: pipeline flush, synchronous.
- `dispatch_valid  in  1`: one instruction is pushed to the ROB this cycle.
- `dispatch_rd_s  in  5`: destination architectural register.
- `dispatch_rob  in  TW`: ROB tag allocated; driven from the ROB's `issue_rob`.
- `rs1_s`, `rs2_s  in  5`: source register indices.
- `rs1_busy`, `rs2_busy  out  1`: source is in flight; consumer waits on the tag.
- `rs1_rob`, `rs2_rob  out  TW`: producer tag, driven to the ROB `issue_rs*_rob` inputs.
- `rs1_v`, `rs2_v  out  32`: committed value; valid when busy=0.
- `commit_valid  in  1`: ROB head retires this cycle.
- `commit_rd_s  in  5`: register written by the retiring entry.
- `commit_rob  in  TW`: tag of the retiring entry.
- `commit_rd_v  in  32`: value written by the retiring entry.
- `order_next  out  64`: `rvfi_order` for the instruction dispatched this cycle.

## Operation
- **State**
  - `regs[1:31]` (32b).
  - `busy[1:31]`.
  - `tag[1:31]` (TW).
  - `dispatch_count` and `commit_count` (64b each).
- **Lookup (combinational)**
  - Index 0: busy=0, v=0, rob=0.
  - Otherwise: busy=`busy[rs]`, rob=`tag[rs]`, v=`regs[rs]`.
  - Lookup returns pre-edge state. A same-cycle dispatch does not affect its own sources, so `add x5,x5,x1` reads the old x5 mapping.
- **Dispatch**
  - When `dispatch_valid` and rd≠0: set `busy[rd]`, `tag[rd]<=dispatch_rob`.
  - `dispatch_count` increments on every `dispatch_valid`, including rd=0.
  - `order_next = dispatch_count`.
- **Commit**
  - When `commit_valid` and rd≠0: `regs[rd]<=commit_rd_v`.
  - `busy[rd]` is cleared only when `tag[rd]==commit_rob`. A newer in-flight writer keeps the mapping.
  - `commit_count` increments on every `commit_valid`.
- **Simultaneous dispatch and commit to the same rd:**
  - The dispatch mapping wins: busy stays 1 and tag becomes `dispatch_rob`.
  - `regs[rd]` still takes `commit_rd_v`.
- **Flush**
  - All `busy` bits are cleared; `regs` and `tag` are kept.
  - `dispatch_count <= commit_count + commit_valid`, so order numbering resumes after the last retired instruction.
  - A `commit_valid` in the flush cycle is still applied to `regs`.
  - A `dispatch_valid` in the flush cycle is ignored: no mapping, no count.
- **Counters** wrap modulo 2^64; no saturation.

## Timing
- **Reset:** asserting `rst` low immediately clears all state. During reset and after release:
  - `rs*_busy=0`, `rs*_rob=0`, `rs*_v=0`.
  - `order_next=0`.
- **Latency:** lookup has zero cycles of latency. Dispatch and commit updates are visible at the first lookup after the next rising edge.
- **Reset mid-operation:** all mappings and counters are lost. The ROB is reset by the same signal.
- **Handshakes:** none. The upstream stage must not assert `dispatch_valid` while the ROB is full.

## Configuration
- `REG_STATUS_COMMIT_BYPASS_EN` defined: when a source hits a register whose busy entry is being cleared this cycle (`commit_valid`, rd match, `tag==commit_rob`), the lookup returns busy=0 and v=`commit_rd_v`.
- Undefined: that lookup returns busy=1 and the old tag; the operand value is obtained from the ROB's `issue_rs*_ready`/`issue_rs*_v` path.

## Test plan
- **Reset and x0:**
  - Stimulus: reset, then look up rs1=0 and rs2=7.
  - Required: busy=0 and v=0 for both, `order_next=0`.
  - Stimulus: dispatch rd=0 with tag 3.
  - Required: `order_next=1`, x0 still not busy.
- **Dispatch then commit:**
  - Stimulus: dispatch rd=5 with tag 2.
  - Required next cycle: rs1=5 gives busy=1, rob=2.
  - Stimulus: commit rd=5, rob=2, v=0xDEADBEEF.
  - Required next cycle: busy=0, v=0xDEADBEEF.
- **Stale commit:**
  - Stimulus: dispatch x5 with tag 2, then x5 with tag 4; commit rob=2, v=0x11.
  - Required: x5 busy=1, rob=4; `regs[5]` holds 0x11.
- **Same-cycle dispatch and commit to x9:**
  - Stimulus: x9 holds tag 1; in one cycle dispatch x9 with tag 6 and commit x9 rob=1, v=0x22.
  - Required: busy=1, rob=6.
  - Required with the macro defined: the same-cycle lookup of x9 returns busy=0, v=0x22.
- **Flush:**
  - Stimulus: 5 dispatches and 2 commits, then flush with `commit_valid=1` in the flush cycle.
  - Required: all busy=0; `order_next=3`; the committed value is written.
- **Async reset:**
  - Stimulus: assert `rst` low between clock edges while registers are busy.
  - Required: outputs drop to their reset values before the next edge.
